// File: rtl/crc_pkg.sv
// Shared CRC constants and frame-checker FSM state encoding.
// The polynomial and seed values are non-reflected and stored 32 bits wide.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC16_CCITT_POLY = 32'h0000_1021;
  localparam logic [31:0] CRC16_CCITT_INIT = 32'h0000_FFFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } frameState_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// Single-beat combinational CRC update.
// The whole beat is shifted in MSB first, with no reflection.
module crc_lfsr_step #(
  parameter int               DATA_W = 32,
  parameter int               CRC_W  = 32,
  parameter logic [CRC_W-1:0] POLY   = {CRC_W{1'b0}}
) (
  input  logic [CRC_W-1:0]  crcCur,
  input  logic [DATA_W-1:0] beatData,
  output logic [CRC_W-1:0]  crcNext
);

  function automatic logic [CRC_W-1:0] stepBeat(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] acc;
    logic             fb;
    acc = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = acc[CRC_W-1] ^ d[i];
      acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
    end
    return acc;
  endfunction

  assign crcNext = stepBeat(crcCur, beatData);

endmodule

// File: rtl/crc_frame_check.sv
// Streaming CRC frame checker.
// Data beats pass through with one beat of look-ahead. The CRC beat is stripped, and its verdict rides on oErr of the last data beat.
module crc_frame_check
  import crc_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          CRC_W  = 32,
  parameter logic [31:0] POLY   = CRC32_POLY,
  parameter logic [31:0] INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] XOROUT = 32'h0000_0000,
  parameter int          CNT_W  = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iVld,
  input  logic              iSop,
  input  logic              iEop,
  input  logic [DATA_W-1:0] iData,
  output logic              oRdy,
  output logic              oVld,
  output logic              oSop,
  output logic              oEop,
  output logic [DATA_W-1:0] oData,
  output logic              oErr,
  input  logic              iReady,
  output logic [CNT_W-1:0]  oGoodCnt,
  output logic [CNT_W-1:0]  oBadCnt
);

  frameState_e       state_r;
  frameState_e       stateNext_s;
  logic              accept_s;
  logic              emit_s;
  logic              emitEop_s;
  logic              emitErr_s;
  logic              loadHold_s;
  logic              seed_s;
  logic              goodInc_s;
  logic              badInc_s;
  logic [CRC_W-1:0]  crc_r;
  logic [CRC_W-1:0]  crcStepIn_s;
  logic [CRC_W-1:0]  crcStepOut_s;
  logic [CRC_W-1:0]  crcFinal_s;
  logic [DATA_W-1:0] holdData_r;
  logic              holdSop_r;
  logic [CNT_W-1:0]  goodCnt_r;
  logic [CNT_W-1:0]  badCnt_r;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // The output register always has room for the beat accepted this cycle.
  assign oRdy        = !oVld || iReady;
  assign accept_s    = iVld && oRdy;
  assign crcStepIn_s = seed_s ? INIT[CRC_W-1:0] : crc_r;
  assign crcFinal_s  = crc_r ^ XOROUT[CRC_W-1:0];
  assign oGoodCnt    = goodCnt_r;
  assign oBadCnt     = badCnt_r;

  crc_lfsr_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY[CRC_W-1:0])
  ) uStep (
    .crcCur   (crcStepIn_s),
    .beatData (iData),
    .crcNext  (crcStepOut_s)
  );

  // FSM state register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    stateNext_s = state_r;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: stateNext_s = (iSop && !iEop) ? ST_BODY : ST_IDLE;
        ST_BODY: stateNext_s = iEop ? ST_IDLE : ST_BODY;
        default: stateNext_s = ST_IDLE;
      endcase
    end else begin
      stateNext_s = state_r;
    end
  end

  // FSM output decode: what an accepted beat does to hold, output and counters
  always_comb begin
    emit_s     = 1'b0;
    emitEop_s  = 1'b0;
    emitErr_s  = 1'b0;
    loadHold_s = 1'b0;
    seed_s     = 1'b1;
    goodInc_s  = 1'b0;
    badInc_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (iSop && !iEop) begin
            loadHold_s = 1'b1;
          end else if (iSop && iEop) begin
            badInc_s = 1'b1;
          end else begin
            badInc_s = 1'b0;
          end
        end
        ST_BODY: begin
          emit_s = 1'b1;
          if (iEop) begin
            emitEop_s = 1'b1;
            emitErr_s = (crcFinal_s != iData[CRC_W-1:0]);
            goodInc_s = !emitErr_s;
            badInc_s  = emitErr_s;
          end else if (iSop) begin
            // An early start-of-frame aborts the open frame and restarts the CRC.
            emitEop_s  = 1'b1;
            emitErr_s  = 1'b1;
            badInc_s   = 1'b1;
            loadHold_s = 1'b1;
          end else begin
            loadHold_s = 1'b1;
            seed_s     = 1'b0;
          end
        end
        default: begin
          emit_s = 1'b0;
        end
      endcase
    end else begin
      emit_s = 1'b0;
    end
  end

  // Hold register and running CRC
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      holdData_r <= {DATA_W{1'b0}};
      holdSop_r  <= 1'b0;
      crc_r      <= INIT[CRC_W-1:0];
    end else if (loadHold_s) begin
      holdData_r <= iData;
      holdSop_r  <= seed_s;
      crc_r      <= crcStepOut_s;
    end
  end

  // Output register and saturating frame counters
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oVld      <= 1'b0;
      oSop      <= 1'b0;
      oEop      <= 1'b0;
      oErr      <= 1'b0;
      oData     <= {DATA_W{1'b0}};
      goodCnt_r <= {CNT_W{1'b0}};
      badCnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (oRdy) begin
        oVld <= emit_s;
        if (emit_s) begin
          oSop  <= holdSop_r;
          oEop  <= emitEop_s;
          oErr  <= emitErr_s;
          oData <= holdData_r;
        end
      end
      if (goodInc_s) begin
        goodCnt_r <= satInc(goodCnt_r);
      end
      if (badInc_s) begin
        badCnt_r <= satInc(badCnt_r);
      end
    end
  end

endmodule

// File: doc/crc_frame_check.md
CRC_FRAME_CHECK -- requirements
Module: crc_frame_check

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning beat width in bits (multiple of 8, 16..128).
REQ-002 SHALL have parameter CRC_W, default 32, meaning CRC width in bits (16 or 32, CRC_W <= DATA_W).
REQ-003 SHALL have parameter POLY, default 32'h04C11DB7, meaning generator polynomial (implicit top bit).
REQ-004 SHALL have parameter INIT, default all-ones, meaning CRC register seed at frame start.
REQ-005 SHALL have parameter XOROUT, default 0, meaning value XORed into the final CRC before compare.
REQ-006 SHALL have parameter CNT_W, default 16, meaning width of the statistics counters.
REQ-007 SHALL have port iClk, input, 1, meaning the single clock.
REQ-008 SHALL have port iRst, input, 1, meaning the reset, asynchronous and active-high.
REQ-009 SHALL have input ports iVld (1), iSop (1), iEop (1) and iData (DATA_W), meaning the upstream beat.
REQ-010 SHALL have port oRdy, output, 1, meaning upstream beat accepted when iVld && oRdy.
REQ-011 SHALL have output ports oVld (1), oSop (1), oEop (1), oData (DATA_W) and oErr (1), meaning the downstream beat; oErr is valid only with oEop.
REQ-012 SHALL have port iReady, input, 1, meaning downstream accepts when oVld && iReady.
REQ-013 SHALL have output ports oGoodCnt (CNT_W) and oBadCnt (CNT_W), meaning frames passed and failed.

Function
REQ-014 SHALL treat each frame as data beats (iSop on the first) followed by one CRC beat (iEop), whose iData[CRC_W-1:0] carries the expected CRC.
REQ-015 SHALL compute the CRC over all DATA_W bits of every data beat, MSB first, non-reflected, seeded with INIT at each iSop, one beat per cycle.
REQ-016 SHALL NOT forward the CRC beat; it SHALL set oEop on the last data beat instead.
REQ-017 SHALL hold each accepted data beat in a one-beat hold register and move it to the output register when the next beat of the same frame is accepted (one-beat look-ahead).
REQ-018 SHALL drive oRdy = !oVld || iReady, so that output-register space is guaranteed whenever a beat is accepted.
REQ-019 SHALL keep oVld, oSop, oEop, oData and oErr stable while oVld && !iReady.
REQ-020 SHALL, on acceptance of the CRC beat, emit the held beat with oEop=1 and oErr = ((crc ^ XOROUT) != iData[CRC_W-1:0]); this is registered and visible the following cycle.
REQ-021 SHALL use a two-state FSM: IDLE to BODY on an accepted beat with iSop && !iEop; BODY to IDLE on an accepted beat with iEop.
REQ-022 SHALL, in IDLE, discard accepted beats without iSop (no output, no counter change).
REQ-023 SHALL, in IDLE, discard a beat with iSop && iEop (frame with no data) and increment oBadCnt.
REQ-024 SHALL, in BODY, treat an accepted beat with iSop as an abort plus restart: the held beat is emitted with oEop=1 and oErr=1, oBadCnt is incremented, the CRC is reseeded, and the new beat becomes the held beat.
REQ-025 SHALL, in BODY, ignore iSop on an accepted beat that also has iEop; the beat is treated as the CRC beat.
REQ-026 SHALL increment oGoodCnt on each frame with oErr=0 and oBadCnt on each with oErr=1, counting when the oEop beat is loaded; both counters saturate at all-ones.
REQ-027 SHALL add no bubbles: with iReady held at 1, a frame of N data beats produces N output beats, back-to-back frames are allowed, and throughput is 1 beat/cycle.

Reset
REQ-028 SHALL, on iRst assertion, immediately clear oVld, oSop, oEop, oErr, oData, the hold register, both counters and the FSM (to IDLE), and set the CRC register to INIT.
REQ-029 SHALL drop any frame in progress at reset assertion without emitting output or counting it.
REQ-030 SHALL drive oRdy=1 in the first cycle after reset release.

Structure
REQ-031 SHALL take standard POLY/INIT constants (CRC-32, CRC-16-CCITT) and the FSM state enum from a shared package crc_pkg.
REQ-032 SHALL place the single-beat combinational CRC update (crc_in, data -> crc_out, parametrised by DATA_W/CRC_W/POLY) in sub-module crc_lfsr_step, instantiated once.

Verification
REQ-033 SHALL cover: INIT=0, XOROUT=0, CRC_W=32, frame of data 32'h00000001 then CRC beat 32'h04C11DB7 -> one output beat with oSop=1, oEop=1, oErr=0 and oGoodCnt=1.
REQ-034 SHALL cover: the same frame with CRC beat 32'h04C11DB6 -> oErr=1, oBadCnt=1, oGoodCnt unchanged.
REQ-035 SHALL cover: INIT=0, frame of 3 zero data beats and a zero CRC beat, with iReady low for 4 cycles mid-frame -> 3 output beats in order with stable outputs while stalled, oEop on the third, oErr=0.
REQ-036 SHALL cover: frame A sends 2 data beats, then iSop arrives before iEop -> A's second beat is emitted with oEop=1, oErr=1, oBadCnt=1, and the new frame then completes normally.
REQ-037 SHALL cover: iSop && iEop beat in IDLE, then a stray beat without iSop -> no output, oBadCnt=1.
REQ-038 SHALL cover: CNT_W=2 with 5 good frames -> oGoodCnt saturates at 3; iRst asserted mid-frame -> outputs clear at once and no count changes.
